// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle between the read clients, the arbiter and the single AXI read port.
// The slave modport is the arbiter's view: it serves the clients' AR/R traffic and
// masters the downstream AR channel. The master modport is the opposite side
// (clients plus downstream memory), used by whatever surrounds the arbiter.
interface axi_rd_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4
);
    // client side
    logic [NUM_MASTERS-1:0]        s_arvalid;
    logic [NUM_MASTERS-1:0]        s_arready;
    logic [NUM_MASTERS*ADDR_W-1:0] s_araddr;
    logic [NUM_MASTERS*8-1:0]      s_arlen;
    logic [NUM_MASTERS*3-1:0]      s_arsize;
    logic [NUM_MASTERS-1:0]        s_rvalid;
    logic [NUM_MASTERS-1:0]        s_rready;
    logic [DATA_W-1:0]             s_rdata;
    logic [1:0]                    s_rresp;
    logic                          s_rlast;

    // downstream AXI read port
    logic [ID_W-1:0]               m_arid;
    logic [ADDR_W-1:0]             m_araddr;
    logic [7:0]                    m_arlen;
    logic [2:0]                    m_arsize;
    logic [1:0]                    m_arburst;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [ID_W-1:0]               m_rid;
    logic [DATA_W-1:0]             m_rdata;
    logic [1:0]                    m_rresp;
    logic                          m_rlast;
    logic                          m_rvalid;
    logic                          m_rready;

    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
        input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    modport master (
        output s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
        output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N-client to 1-port AXI read arbiter. Round-robin grant on AR, client index used as
// the AXI ID, one outstanding burst per client, R beats steered back by ID.
//
// state | meaning
// IDLE  | no AR pending downstream; an eligible client is accepted combinationally
// ISSUE | latched AR presented on m_ar*, waiting for m_arready
module axi_rd_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_rd_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] busy
);
    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       ar_idx;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_vld;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] busy_set;
    logic [NUM_MASTERS-1:0] busy_clr;
    logic                   rid_ok;
    logic [PTR_W-1:0]       rid_idx;

    // rr_ptr and offset are both below NUM_MASTERS, so a single subtract wraps
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin pick: first eligible client at or after rr_ptr. The loop walks
    // downwards so the closest candidate to rr_ptr is the last one written.
    always_comb begin
        eligible  = bus.s_arvalid & ~busy;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (eligible[wrap_idx(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Client acceptance depends on state/busy/s_arvalid only, never on m_arready
    always_comb begin
        bus.s_arready = '0;
        if (aresetn && state == IDLE && grant_vld) begin
            bus.s_arready[grant_idx] = 1'b1;
        end
    end

    // AR FSM: latch the granted client's request, hold it until the downstream handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            ar_idx        <= '0;
            bus.m_arvalid <= 1'b0;
            bus.m_arid    <= '0;
            bus.m_araddr  <= '0;
            bus.m_arlen   <= '0;
            bus.m_arsize  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ar_idx        <= grant_idx;
                        bus.m_arid    <= ID_W'(grant_idx);
                        bus.m_araddr  <= bus.s_araddr[int'(grant_idx) * ADDR_W +: ADDR_W];
                        bus.m_arlen   <= bus.s_arlen[int'(grant_idx) * 8 +: 8];
                        bus.m_arsize  <= bus.s_arsize[int'(grant_idx) * 3 +: 3];
                        bus.m_arvalid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.m_arready) begin
                        bus.m_arvalid <= 1'b0;
                        rr_ptr        <= (ar_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : ar_idx + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.m_arvalid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_arburst = 2'b01;

    // IDs at or above NUM_MASTERS belong to nobody; those beats are sunk
    assign rid_ok  = ({1'b0, bus.m_rid} < (ID_W + 1)'(NUM_MASTERS));
    assign rid_idx = bus.m_rid[PTR_W-1:0];

    // R steering: purely combinational, no added latency
    always_comb begin
        bus.s_rvalid = '0;
        bus.m_rready = 1'b1;
        if (rid_ok) begin
            bus.m_rready = bus.s_rready[rid_idx];
            if (aresetn) begin
                bus.s_rvalid[rid_idx] = bus.m_rvalid;
            end
        end
    end

    assign bus.s_rdata = bus.m_rdata;
    assign bus.s_rresp = bus.m_rresp;
    assign bus.s_rlast = bus.m_rlast;

    // Set on AR handshake, clear on the last R handshake of that client's burst
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (state == ISSUE && bus.m_arready) begin
            busy_set[ar_idx] = 1'b1;
        end
        if (rid_ok && bus.m_rvalid && bus.m_rlast && bus.s_rready[rid_idx]) begin
            busy_clr[rid_idx] = 1'b1;
        end
    end

    // Outstanding-burst flags, one per client
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against a transaction-level reference model of the arbitration rules.
module tb_axi_rd_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic         aclk    = 1'b0;
    logic         aresetn = 1'b1;
    logic [N-1:0] busy;

    axi_rd_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    axi_rd_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one pending AR record, busy flags, round-robin pointer
    bit          mdl_pend;
    int          mdl_pidx;
    logic [AW-1:0] mdl_paddr;
    logic [7:0]  mdl_plen;
    logic [2:0]  mdl_psize;
    bit          mdl_busy [N];
    int          mdl_ptr;
    int          beats_left [N];
    int          grant_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_pend = 1'b0;
        mdl_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            mdl_busy[i]   = 1'b0;
            beats_left[i] = 0;
        end
    endtask

    task automatic inputs_idle();
        bus.s_arvalid = '0;
        bus.s_araddr  = '0;
        bus.s_arlen   = '0;
        bus.s_arsize  = '0;
        bus.s_rready  = '1;
        bus.m_arready = 1'b1;
        bus.m_rid     = '0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rlast   = 1'b0;
        bus.m_rvalid  = 1'b0;
    endtask

    task automatic set_req(input int c, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
        bus.s_arvalid[c]           = 1'b1;
        bus.s_araddr[c*AW +: AW]   = addr;
        bus.s_arlen[c*8 +: 8]      = len;
        bus.s_arsize[c*3 +: 3]     = size;
    endtask

    task automatic drive_beat(input int id, input bit last);
        bus.m_rvalid = 1'b1;
        bus.m_rid    = IW'(id);
        bus.m_rlast  = last;
        bus.m_rdata  = $urandom;
        bus.m_rresp  = 2'($urandom_range(0, 3));
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic step();
        int           g;
        int           rid;
        logic [N-1:0] exp_ardy;
        logic [N-1:0] exp_rv;
        logic         exp_rrdy;
        logic [N-1:0] bv;
        #1;
        g = -1;
        if (!mdl_pend) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mdl_ptr + k) % N;
                if (g < 0 && bus.s_arvalid[c] && !mdl_busy[c]) g = c;
            end
        end
        exp_ardy = '0;
        if (g >= 0) exp_ardy[g] = 1'b1;
        for (int i = 0; i < N; i++) bv[i] = mdl_busy[i];
        chk("s_arready", bus.s_arready, exp_ardy);
        chk("m_arvalid", bus.m_arvalid, mdl_pend);
        chk("m_arburst", bus.m_arburst, 2'b01);
        chk("busy", busy, bv);
        if (mdl_pend) begin
            chk("m_arid", bus.m_arid, mdl_pidx);
            chk("m_araddr", bus.m_araddr, mdl_paddr);
            chk("m_arlen", bus.m_arlen, mdl_plen);
            chk("m_arsize", bus.m_arsize, mdl_psize);
        end
        rid      = int'(bus.m_rid);
        exp_rv   = '0;
        exp_rrdy = 1'b1;
        if (rid < N) begin
            exp_rv[rid] = bus.m_rvalid;
            exp_rrdy    = bus.s_rready[rid];
        end
        chk("s_rvalid", bus.s_rvalid, exp_rv);
        chk("m_rready", bus.m_rready, exp_rrdy);
        chk("s_rdata", bus.s_rdata, bus.m_rdata);
        chk("s_rresp", bus.s_rresp, bus.m_rresp);
        chk("s_rlast", bus.s_rlast, bus.m_rlast);

        if (bus.m_rvalid && exp_rrdy && rid < N) begin
            if (beats_left[rid] > 0) beats_left[rid]--;
            if (bus.m_rlast) mdl_busy[rid] = 1'b0;
        end
        if (mdl_pend && bus.m_arready) begin
            grant_log.push_back(int'(bus.m_arid));
            mdl_busy[mdl_pidx]   = 1'b1;
            beats_left[mdl_pidx] = int'(mdl_plen) + 1;
            mdl_ptr              = (mdl_pidx + 1) % N;
            mdl_pend             = 1'b0;
        end else if (g >= 0) begin
            mdl_pend  = 1'b1;
            mdl_pidx  = g;
            mdl_paddr = bus.s_araddr[g*AW +: AW];
            mdl_plen  = bus.s_arlen[g*8 +: 8];
            mdl_psize = bus.s_arsize[g*3 +: 3];
        end
        @(posedge aclk);
        #1;
    endtask

    // Reset with requests and an R beat active, check reset values, release after an edge
    task automatic do_reset();
        aresetn       = 1'b0;
        bus.s_arvalid = '1;
        bus.m_rvalid  = 1'b1;
        bus.m_rid     = '0;
        #1;
        chk("rst_m_arvalid", bus.m_arvalid, 0);
        chk("rst_m_arid", bus.m_arid, 0);
        chk("rst_m_araddr", bus.m_araddr, 0);
        chk("rst_m_arlen", bus.m_arlen, 0);
        chk("rst_m_arsize", bus.m_arsize, 0);
        chk("rst_s_arready", bus.s_arready, 0);
        chk("rst_s_rvalid", bus.s_rvalid, 0);
        chk("rst_busy", busy, 0);
        @(posedge aclk);
        #1;
        inputs_idle();
        aresetn = 1'b1;
        mdl_reset();
    endtask

    // Completes any outstanding burst one beat per cycle, always accepted
    task automatic r_complete();
        bus.m_rvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!bus.m_rvalid && mdl_busy[i] && beats_left[i] > 0) drive_beat(i, beats_left[i] == 1);
        end
    endtask

    task automatic rand_r();
        int cand [$];
        for (int i = 0; i < N; i++) if (mdl_busy[i] && beats_left[i] > 0) cand.push_back(i);
        if ($urandom_range(0, 9) == 0) begin
            drive_beat($urandom_range(N, 15), bit'($urandom_range(0, 1)));
        end else if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
            int id;
            id = cand[$urandom_range(0, cand.size() - 1)];
            drive_beat(id, beats_left[id] == 1);
        end else begin
            bus.m_rvalid = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 0, 1};
        inputs_idle();
        mdl_reset();
        #2;
        do_reset();

        // single client, 4-beat burst
        set_req(0, 32'h1FC0_0000, 8'd3, 3'd2);
        step();
        bus.s_arvalid = '0;
        chk("t1_arvalid", bus.m_arvalid, 1);
        chk("t1_araddr", bus.m_araddr, 32'h1FC0_0000);
        chk("t1_arid", bus.m_arid, 0);
        chk("t1_arlen", bus.m_arlen, 3);
        step();
        for (int b = 0; b < 4; b++) begin
            chk("t1_busy_set", busy, 3'b001);
            drive_beat(0, b == 3);
            step();
        end
        bus.m_rvalid = 1'b0;
        chk("t1_busy_clr", busy, 3'b000);
        step();

        // all clients requesting, single-beat bursts completed at once
        do_reset();
        grant_log.delete();
        for (int c = 0; c < N; c++) set_req(c, 32'h100 * c, 8'd0, 3'd2);
        repeat (14) begin
            r_complete();
            step();
        end
        chk("t2_count", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], exp_order[i]);
        inputs_idle();
        repeat (3) begin
            r_complete();
            step();
        end

        // two bursts outstanding, interleaved R, one stray beat
        do_reset();
        set_req(2, 32'h2000_0000, 8'd1, 3'd2);
        step();
        bus.s_arvalid = '0;
        step();
        set_req(0, 32'h0000_4000, 8'd1, 3'd2);
        step();
        bus.s_arvalid = '0;
        step();
        chk("t3_busy_both", busy, 3'b101);
        drive_beat(2, 1'b0);
        step();
        drive_beat(0, 1'b0);
        step();
        drive_beat(2, 1'b1);
        step();
        chk("t3_busy_2clr", busy, 3'b001);
        bus.s_rready = '0;
        drive_beat(7, 1'b1);
        step();
        chk("t3_stray_busy", busy, 3'b001);
        bus.s_rready = '1;
        drive_beat(0, 1'b1);
        step();
        bus.m_rvalid = 1'b0;
        chk("t3_busy_0clr", busy, 3'b000);
        step();

        // busy client 1 re-requesting is skipped until its burst ends
        do_reset();
        set_req(1, 32'h1111_0000, 8'd0, 3'd0);
        step();
        bus.s_arvalid = '0;
        step();
        set_req(0, 32'h0000_0040, 8'd0, 3'd0);
        set_req(1, 32'h1111_0100, 8'd0, 3'd0);
        step();
        chk("t4_grant0", bus.m_arid, 0);
        bus.s_arvalid[0] = 1'b0;
        step();
        repeat (2) begin
            step();
            chk("t4_stall_busy", busy[1], 1);
        end
        drive_beat(1, 1'b1);
        step();
        bus.m_rvalid = 1'b0;
        step();
        chk("t4_grant1", bus.m_arid, 1);
        chk("t4_grant1_addr", bus.m_araddr, 32'h1111_0100);
        bus.s_arvalid = '0;
        step();

        // AR held for 5 cycles of backpressure
        do_reset();
        set_req(0, 32'hCAFE_0000, 8'd5, 3'd2);
        bus.m_arready = 1'b0;
        step();
        bus.s_arvalid = 3'b110;
        repeat (5) begin
            step();
            chk("t5_hold_valid", bus.m_arvalid, 1);
            chk("t5_hold_addr", bus.m_araddr, 32'hCAFE_0000);
        end
        bus.m_arready = 1'b1;
        step();
        chk("t5_idle", bus.m_arvalid, 0);
        bus.s_arvalid = '0;
        step();

        // asynchronous reset in the middle of a burst
        do_reset();
        set_req(0, 32'h0000_8000, 8'd3, 3'd2);
        step();
        bus.s_arvalid = '0;
        step();
        set_req(2, 32'h0000_9000, 8'd0, 3'd0);
        bus.m_arready = 1'b0;
        drive_beat(0, 1'b0);
        step();
        bus.s_arvalid = '0;
        drive_beat(0, 1'b0);
        #1;
        chk("t6_pre_rvalid", bus.s_rvalid, 3'b001);
        chk("t6_pre_arvalid", bus.m_arvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_arvalid", bus.m_arvalid, 0);
        chk("t6_rvalid", bus.s_rvalid, 0);
        chk("t6_busy", busy, 0);
        bus.m_rvalid = 1'b0;
        @(posedge aclk);
        #1;
        inputs_idle();
        aresetn = 1'b1;
        mdl_reset();
        set_req(1, 32'h0000_A000, 8'd0, 3'd0);
        step();
        bus.s_arvalid = '0;
        chk("t6_arid", bus.m_arid, 1);
        step();

        // random traffic
        do_reset();
        repeat (1500) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(c, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                else
                    bus.s_arvalid[c] = 1'b0;
            end
            bus.m_arready = 1'($urandom_range(0, 1));
            bus.s_rready  = N'($urandom);
            rand_r();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
